// File: rtl/w_ram_from_uart_pkg.sv
// Shared constants and state encodings for the UART-to-RAM writer and its receiver.
// The block size and address width defaults are also used by r_ram_from_uart.
package w_ram_from_uart_pkg;

   localparam int DEF_FULL_NUMBER = 32;
   localparam int DEF_ADDR_W      = 15;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_t;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_WRITE,
      WR_DONE
   } wr_state_t;

endpackage

// File: rtl/w_ram_from_uart_rx.sv
// UART receiver (8N1, LSB first), the counterpart of uart_tx. Produces a one-cycle
// rx_done with the byte, or a one-cycle frame_err when the stop bit reads 0.
module w_ram_from_uart_rx
   import w_ram_from_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rxd,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       frame_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic             rxd_meta;
   logic             rxd_sync;
   rx_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;

   // NOTE: non-blocking (<=) on every register, so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
      end else begin
         rxd_meta <= uart_rxd;
         rxd_sync <= rxd_meta;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RX_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         rx_data   <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (!rxd_sync) begin
                  state <= RX_START;
                  cnt   <= '0;
               end
            end
            RX_START: begin
               // Mid-start-bit resample rejects glitches shorter than half a bit.
               if (cnt == HALF_CNT) begin
                  cnt <= '0;
                  if (!rxd_sync) begin
                     state   <= RX_DATA;
                     bit_idx <= '0;
                  end else begin
                     state <= RX_IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (cnt == LAST_CNT) begin
                  cnt     <= '0;
                  rx_data <= {rxd_sync, rx_data[7:1]};
                  if (bit_idx == 3'd7) state <= RX_STOP;
                  else                 bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (cnt == LAST_CNT) begin
                  cnt <= '0;
                  if (rxd_sync) begin
                     rx_done <= 1'b1;
                     state   <= RX_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= RX_WAIT_IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_WAIT_IDLE: begin
               if (rxd_sync) state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/w_ram_from_uart.sv
// Receives FULL_NUMBER bytes over UART and writes them to RAM at addresses 0..FULL_NUMBER-1,
// then raises uw_ram_end until uw_ram_start drops.
module w_ram_from_uart
   import w_ram_from_uart_pkg::*;
#(
   parameter int CLK_FREQ     = 50000000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
   parameter int FULL_NUMBER  = DEF_FULL_NUMBER,
   parameter int ADDR_W       = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              uw_ram_start,
   input  logic              uart_rxd,
   output logic [ADDR_W-1:0] address,
   output logic [7:0]        wr_data,
   output logic              wr_en,
   output logic              frame_err,
   output logic              uw_ram_end
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FULL_NUMBER - 1);

   logic [7:0]        rx_data;
   logic              rx_done;
   logic [ADDR_W-1:0] count;
   wr_state_t         state;

   w_ram_from_uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk      (clk),
      .reset    (reset),
      .uart_rxd (uart_rxd),
      .rx_data  (rx_data),
      .rx_done  (rx_done),
      .frame_err(frame_err)
   );

   assign address = count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= WR_IDLE;
         count      <= '0;
         wr_data    <= '0;
         wr_en      <= 1'b0;
         uw_ram_end <= 1'b0;
      end else if (!uw_ram_start) begin
         // Dropping start aborts the block; the receiver keeps running and its bytes are dropped.
         state      <= WR_IDLE;
         count      <= '0;
         wr_en      <= 1'b0;
         uw_ram_end <= 1'b0;
      end else begin
         case (state)
            WR_IDLE: begin
               if (rx_done && !uw_ram_end) begin
                  wr_data <= rx_data;
                  wr_en   <= 1'b1;
                  state   <= WR_WRITE;
               end
            end
            WR_WRITE: begin
               wr_en <= 1'b0;
               count <= count + ADDR_W'(1);
               if (count == LAST_ADDR) begin
                  state      <= WR_DONE;
                  uw_ram_end <= 1'b1;
               end else begin
                  state <= WR_IDLE;
               end
            end
            WR_DONE: uw_ram_end <= 1'b1;
            default: state <= WR_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_w_ram_from_uart.sv
// Scoreboard bench: a byte-level model predicts RAM writes and frame errors as bytes are sent;
// a negedge monitor pops and compares whenever the DUT strobes wr_en.
module tb_w_ram_from_uart;

   localparam int CPB  = 16;
   localparam int FULL = 32;
   localparam int AW   = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic          uw_ram_start;
   logic          uart_rxd;
   logic [AW-1:0] address;
   logic [7:0]    wr_data;
   logic          wr_en;
   logic          frame_err;
   logic          uw_ram_end;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks  = 0;
   int  n_errors  = 0;
   int  m_count   = 0;
   bit  m_done    = 1'b0;
   bit  m_start   = 1'b0;
   int  ferr_exp  = 0;
   int  ferr_seen = 0;
   bit  end_due   = 1'b0;

   w_ram_from_uart #(
      .CLKS_PER_BIT(CPB),
      .FULL_NUMBER (FULL),
      .ADDR_W      (AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .uw_ram_start(uw_ram_start),
      .uart_rxd    (uart_rxd),
      .address     (address),
      .wr_data     (wr_data),
      .wr_en       (wr_en),
      .frame_err   (frame_err),
      .uw_ram_end  (uw_ram_end)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: a good byte is written at the next address while a block is open.
   task automatic model_byte(input logic [7:0] b, input bit good);
      wr_t e;
      if (!good) begin
         ferr_exp++;
      end else if (m_start && !m_done) begin
         e.addr = AW'(m_count);
         e.data = b;
         exp_q.push_back(e);
         m_count++;
         if (m_count == FULL) m_done = 1'b1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit good);
      model_byte(b, good);
      @(negedge clk) uart_rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rxd = good;
      repeat (CPB) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (good ? 4 : CPB) @(negedge clk);
   endtask

   task automatic drop_start(input int hold);
      @(negedge clk) uw_ram_start = 1'b0;
      m_start = 1'b0;
      m_count = 0;
      m_done  = 1'b0;
      @(negedge clk);
      check("end_clear", uw_ram_end, 0);
      check("addr_clear", address, 0);
      repeat (hold - 1) @(negedge clk);
      uw_ram_start = 1'b1;
      m_start      = 1'b1;
   endtask

   task automatic sync_point(input string name);
      repeat (4) @(negedge clk);
      check({name, "_pending"}, exp_q.size(), 0);
      check({name, "_ferr"}, ferr_seen, ferr_exp);
      check({name, "_addr"}, address, AW'(m_count));
      check({name, "_end"}, uw_ram_end, m_done);
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_address"}, address, 0);
      check({name, "_wr_data"}, wr_data, 0);
      check({name, "_wr_en"}, wr_en, 0);
      check({name, "_frame_err"}, frame_err, 0);
      check({name, "_end"}, uw_ram_end, 0);
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (end_due) begin
         check("end_latency", uw_ram_end, 1);
         end_due = 1'b0;
      end
      if (frame_err) ferr_seen++;
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_wr_en: address=%0d data=%0d, expected no write", address, wr_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", address, e.addr);
            check("wr_data", wr_data, e.data);
            check("end_during_block", uw_ram_end, 0);
            if (e.addr == AW'(FULL - 1)) end_due = 1'b1;
         end
      end
   end

   initial begin
      reset        = 1'b0;
      uw_ram_start = 1'b1;
      uart_rxd     = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset   = 1'b1;
      m_start = 1'b1;
      repeat (2) @(negedge clk);

      // Full block of 0x00..0x1F, then bytes after completion are ignored.
      for (int i = 0; i < FULL; i++) send_byte(8'(i), 1'b1);
      sync_point("block");
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
      sync_point("after_done");
      drop_start(1);
      sync_point("restart");

      // Bad stop bit: no write, then the next good byte lands at address 0.
      send_byte(8'hA5, 1'b0);
      sync_point("frame_err");
      send_byte(8'h3C, 1'b1);
      sync_point("after_ferr");

      // Abort mid-block.
      drop_start(1);
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
      sync_point("five");
      drop_start(1);
      send_byte(8'h77, 1'b1);
      sync_point("abort");

      // Low glitch shorter than half a bit.
      @(negedge clk) uart_rxd = 1'b0;
      repeat (4) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      sync_point("glitch");

      // Reset during data bit 4 of 0x5A.
      @(negedge clk) uart_rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         uart_rxd = i[0] ? 1'b1 : 1'b0;
         repeat (CPB) @(negedge clk);
      end
      uart_rxd = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      reset   = 1'b0;
      m_count = 0;
      m_done  = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("mid_reset");
      repeat (CPB) @(negedge clk);
      reset = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      send_byte(8'h81, 1'b1);
      sync_point("after_reset");

      // Randomized traffic with occasional bad stops and start drops.
      drop_start(1);
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 39) == 0) drop_start(1 + $urandom_range(0, 3));
         send_byte(8'($urandom), $urandom_range(0, 7) != 0);
      end
      sync_point("random");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
